regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, number of architectural registers; SHALL be a power of two, >= 2.
REQ-003 Parameter NRD, default 2, number of read ports; legal range 1..4.
REQ-004 Parameter AW, default $clog2(NREGS), register address width (derived, not overridden).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rest  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 rd_en_i  input  NRD  per-port read valid; port k = bit k.
REQ-008 rd_addr_i  input  NRD*AW  read addresses; port k = bits [k*AW +: AW].
REQ-009 rd_data_o  output  NRD*XLEN  read data, port k = bits [k*XLEN +: XLEN].
REQ-010 rd_busy_o  output  NRD  port k source pending (not yet written back).
REQ-011 wb0_we_i / wb0_addr_i / wb0_data_i  input  1 / AW / XLEN  write port 0 (EX result).
REQ-012 wb1_we_i / wb1_addr_i / wb1_data_i  input  1 / AW / XLEN  write port 1 (load result).
REQ-013 iss_we_i / iss_addr_i  input  1 / AW  issue of an instruction that will write iss_addr_i.
REQ-014 hazard_o  output  1  stall request to ID.

Function
REQ-015 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be busy; writes/issues to address 0 are ignored.
REQ-016 Writes: on rising clk, wbN_we_i=1 with nonzero address writes wbN_data_i; if both ports target the same nonzero address in one cycle, port 1 data SHALL be stored.
REQ-017 Read is combinational: rd_data_o[k] = 0 if rd_en_i[k]=0 or address 0.
REQ-018 Bypass: if a write port targets rd_addr_i[k] (nonzero, we=1) in the same cycle, rd_data_o[k] SHALL return that write data (port 1 over port 0), else the stored value.
REQ-019 Scoreboard: one busy bit per register, all 0 after reset.
REQ-020 Busy set: iss_we_i=1, nonzero iss_addr_i, and hazard_o=0 -> busy[iss_addr_i] set at the next edge.
REQ-021 Busy clear: wbN_we_i=1 with nonzero address clears that busy bit at the next edge.
REQ-022 Simultaneous set and clear of the same register: set SHALL win (bit stays 1).
REQ-023 rd_busy_o[k] = rd_en_i[k] & busy[addr] & no write port targeting addr this cycle; 0 for address 0.
REQ-024 hazard_o = OR of rd_busy_o, OR (iss_we_i & busy[iss_addr_i] & not cleared this cycle) (WAW); purely combinational, zero latency.
REQ-025 When hazard_o=1 the issue SHALL NOT set any busy bit; writes still proceed.
REQ-026 Write with busy bit already 0 (spurious write-back) SHALL still update data and leave busy 0.

Reset
REQ-027 rest=0 SHALL asynchronously clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-028 While rest=0, rd_data_o, rd_busy_o and hazard_o SHALL be 0 and all write/issue inputs ignored.
REQ-029 On rest deassert mid-operation, the first write or issue SHALL take effect on the first rising clk with rest=1.

Verification
REQ-030 Reset, then read all addresses on both ports -> every rd_data_o=0, rd_busy_o=0, hazard_o=0.
REQ-031 wb0 write 0xDEADBEEF to x5, same cycle read x5 on port 0 -> rd_data_o=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF.
REQ-032 wb0 writes 0x11, wb1 writes 0x22, both to x7 same cycle -> x7 reads 0x22 afterwards; write 0x55 to x0 -> x0 reads 0.
REQ-033 Issue x3; next cycle read x3 -> rd_busy_o=1, hazard_o=1; issue x3 again -> hazard_o=1, no state change; wb1 writes 0x1234 to x3 -> same-cycle read returns 0x1234, busy=0, hazard_o=0.
REQ-034 Same cycle: issue x9 and wb0 write x9 with busy[x9]=0 -> busy[x9]=1 afterwards.
REQ-035 Write 0xA5A5A5A5 to x10, issue x11, assert rest=0 between edges -> x10 reads 0 and busy cleared immediately, before next clk edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard: combinational reads with
// write-back bypass, two write-back ports, issue tracking and a zero-latency stall request.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rest,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wb0_we_i,
    input  logic [AW-1:0]       wb0_addr_i,
    input  logic [XLEN-1:0]     wb0_data_i,
    input  logic                wb1_we_i,
    input  logic [AW-1:0]       wb1_addr_i,
    input  logic [XLEN-1:0]     wb1_data_i,
    input  logic                iss_we_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic                hazard_o
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic             wr0;
    logic             wr1;
    logic [AW-1:0]    raddr [NRD];
    logic [NRD-1:0]   hit0;
    logic [NRD-1:0]   hit1;
    logic             iss_ok;
    logic             iss_clr;
    logic             iss_set;

    // Writes to x0 are dropped here so x0 is never written, bypassed or cleared.
    always_comb begin
        wr0 = wb0_we_i && (wb0_addr_i != '0);
        wr1 = wb1_we_i && (wb1_addr_i != '0);
    end

    // Unpack read addresses and find same-cycle write-back matches per port.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int k = 0; k < NRD; k++) begin
            raddr[k] = rd_addr_i[k*AW +: AW];
            hit0[k]  = wr0 && (wb0_addr_i == raddr[k]);
            hit1[k]  = wr1 && (wb1_addr_i == raddr[k]);
        end
    end

    // Read ports: port 1 bypass has priority over port 0, then stored value.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rest && rd_en_i[k] && (raddr[k] != '0)) begin
                if (hit1[k]) begin
                    rd_data_o[k*XLEN +: XLEN] = wb1_data_i;
                end else if (hit0[k]) begin
                    rd_data_o[k*XLEN +: XLEN] = wb0_data_i;
                end else begin
                    rd_data_o[k*XLEN +: XLEN] = regs[raddr[k]];
                end
                rd_busy_o[k] = busy[raddr[k]] && !hit0[k] && !hit1[k];
            end
        end
    end

    // Stall on any pending source, or on a WAW against a destination not retiring this cycle.
    always_comb begin
        iss_ok   = iss_we_i && (iss_addr_i != '0);
        iss_clr  = (wr0 && (wb0_addr_i == iss_addr_i)) || (wr1 && (wb1_addr_i == iss_addr_i));
        hazard_o = rest && ((|rd_busy_o) || (iss_ok && busy[iss_addr_i] && !iss_clr));
        iss_set  = rest && iss_ok && !hazard_o;
    end

    // Later assignments win: wb1 data over wb0, and a new issue over a write-back clear.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr0) begin
                regs[wb0_addr_i] <= wb0_data_i;
                busy[wb0_addr_i] <= 1'b0;
            end
            if (wr1) begin
                regs[wb1_addr_i] <= wb1_data_i;
                busy[wb1_addr_i] <= 1'b0;
            end
            if (iss_set) begin
                busy[iss_addr_i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb, checked against an array-based model of
// architectural state (values and pending-writer flags).
module tb_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                clk;
    logic                rest;
    logic [NRD-1:0]      rd_en_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                wb0_we_i;
    logic [AW-1:0]       wb0_addr_i;
    logic [XLEN-1:0]     wb0_data_i;
    logic                wb1_we_i;
    logic [AW-1:0]       wb1_addr_i;
    logic [XLEN-1:0]     wb1_data_i;
    logic                iss_we_i;
    logic [AW-1:0]       iss_addr_i;
    logic                hazard_o;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .rest       (rest),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wb0_we_i   (wb0_we_i),
        .wb0_addr_i (wb0_addr_i),
        .wb0_data_i (wb0_data_i),
        .wb1_we_i   (wb1_we_i),
        .wb1_addr_i (wb1_addr_i),
        .wb1_data_i (wb1_data_i),
        .iss_we_i   (iss_we_i),
        .iss_addr_i (iss_addr_i),
        .hazard_o   (hazard_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_val     [NREGS];
    bit              m_pending [NREGS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit retiring(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return (wb0_we_i && wb0_addr_i == a) || (wb1_we_i && wb1_addr_i == a);
    endfunction

    // Value the architecture holds for a once this cycle's write-backs land.
    function automatic logic [31:0] newest(input logic [AW-1:0] a);
        if (wb1_we_i && wb1_addr_i == a) return wb1_data_i;
        if (wb0_we_i && wb0_addr_i == a) return wb0_data_i;
        return m_val[a];
    endfunction

    function automatic logic [AW-1:0] port_addr(input int k);
        return rd_addr_i[k*AW +: AW];
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        logic [AW-1:0] a;
        a = port_addr(k);
        if (!rest || !rd_en_i[k] || a == 0) return 32'h0;
        return newest(a);
    endfunction

    function automatic bit exp_busy(input int k);
        logic [AW-1:0] a;
        a = port_addr(k);
        return rest && rd_en_i[k] && (a != 0) && m_pending[a] && !retiring(a);
    endfunction

    function automatic bit exp_hazard();
        bit waw;
        waw = iss_we_i && (iss_addr_i != 0) && m_pending[iss_addr_i] && !retiring(iss_addr_i);
        return rest && (exp_busy(0) || exp_busy(1) || waw);
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < int'(NRD); k++) begin
            chk($sformatf("%s_data%0d", tag, k), rd_data_o[k*XLEN +: XLEN], exp_data(k));
            chk($sformatf("%s_busy%0d", tag, k), 32'(rd_busy_o[k]), 32'(exp_busy(k)));
        end
        chk($sformatf("%s_hazard", tag), 32'(hazard_o), 32'(exp_hazard()));
    endtask

    // Advance one clock, retiring write-backs and recording an accepted issue.
    task automatic tick();
        bit stall;
        stall = exp_hazard();
        if (rest) begin
            if (wb0_we_i && wb0_addr_i != 0) begin
                m_val[wb0_addr_i]     = wb0_data_i;
                m_pending[wb0_addr_i] = 1'b0;
            end
            if (wb1_we_i && wb1_addr_i != 0) begin
                m_val[wb1_addr_i]     = wb1_data_i;
                m_pending[wb1_addr_i] = 1'b0;
            end
            if (iss_we_i && iss_addr_i != 0 && !stall) m_pending[iss_addr_i] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en_i = '0; rd_addr_i = '0;
        wb0_we_i = 1'b0; wb0_addr_i = '0; wb0_data_i = '0;
        wb1_we_i = 1'b0; wb1_addr_i = '0; wb1_data_i = '0;
        iss_we_i = 1'b0; iss_addr_i = '0;
    endtask

    task automatic set_rd(input int k, input bit en, input logic [AW-1:0] a);
        rd_en_i[k] = en;
        rd_addr_i[k*AW +: AW] = a;
    endtask

    task automatic model_clear();
        for (int r = 0; r < int'(NREGS); r++) begin
            m_val[r] = '0;
            m_pending[r] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rest = 1'b0;
        idle();
        model_clear();
        #3;
        // Activity during reset must be invisible and ignored.
        wb0_we_i = 1'b1; wb0_addr_i = 5'd5; wb0_data_i = 32'hCAFE0001;
        wb1_we_i = 1'b1; wb1_addr_i = 5'd6; wb1_data_i = 32'hCAFE0002;
        iss_we_i = 1'b1; iss_addr_i = 5'd8;
        set_rd(0, 1'b1, 5'd5); set_rd(1, 1'b1, 5'd6);
        #1 check_all("in_reset");
        tick();
        check_all("in_reset_edge");
        idle();
        rest = 1'b1;

        for (int a = 0; a < int'(NREGS); a++) begin
            set_rd(0, 1'b1, AW'(a)); set_rd(1, 1'b1, AW'(31 - a));
            #1 check_all("post_reset");
        end
        @(posedge clk); #1;

        // Same-cycle bypass then stored value.
        idle();
        wb0_we_i = 1'b1; wb0_addr_i = 5'd5; wb0_data_i = 32'hDEADBEEF;
        set_rd(0, 1'b1, 5'd5);
        #1 check_all("bypass");
        chk("bypass_x5", rd_data_o[31:0], 32'hDEADBEEF);
        tick();
        idle(); set_rd(0, 1'b1, 5'd5);
        #1 chk("stored_x5", rd_data_o[31:0], 32'hDEADBEEF);

        // Dual write to one register: port 1 wins; x0 stays zero.
        tick();
        wb0_we_i = 1'b1; wb0_addr_i = 5'd7; wb0_data_i = 32'h11;
        wb1_we_i = 1'b1; wb1_addr_i = 5'd7; wb1_data_i = 32'h22;
        tick();
        idle(); set_rd(0, 1'b1, 5'd7);
        wb0_we_i = 1'b1; wb0_addr_i = 5'd0; wb0_data_i = 32'h55;
        set_rd(1, 1'b1, 5'd0);
        #1 chk("dual_wr_x7", rd_data_o[31:0], 32'h22);
        chk("x0_bypass", rd_data_o[63:32], 32'h0);
        tick();
        idle(); set_rd(0, 1'b1, 5'd0);
        #1 chk("x0_stored", rd_data_o[31:0], 32'h0);
        check_all("x0");

        // Issue, RAW and WAW stalls, then write-back release.
        tick();
        iss_we_i = 1'b1; iss_addr_i = 5'd3;
        #1 chk("iss_x3_hz", 32'(hazard_o), 32'h0);
        tick();
        idle(); set_rd(0, 1'b1, 5'd3);
        #1 chk("raw_busy", 32'(rd_busy_o[0]), 32'h1);
        chk("raw_hazard", 32'(hazard_o), 32'h1);
        set_rd(0, 1'b0, 5'd0);
        iss_we_i = 1'b1; iss_addr_i = 5'd3;
        #1 chk("waw_hazard", 32'(hazard_o), 32'h1);
        tick();
        idle();
        wb1_we_i = 1'b1; wb1_addr_i = 5'd3; wb1_data_i = 32'h1234;
        set_rd(0, 1'b1, 5'd3);
        #1 chk("wb_x3_data", rd_data_o[31:0], 32'h1234);
        chk("wb_x3_busy", 32'(rd_busy_o[0]), 32'h0);
        chk("wb_x3_hazard", 32'(hazard_o), 32'h0);
        tick();
        idle(); set_rd(0, 1'b1, 5'd3);
        #1 chk("x3_released", 32'(rd_busy_o[0]), 32'h0);

        // Issue and spurious write-back to the same idle register: busy wins.
        tick();
        iss_we_i = 1'b1; iss_addr_i = 5'd9;
        wb0_we_i = 1'b1; wb0_addr_i = 5'd9; wb0_data_i = 32'h99;
        #1 check_all("set_clr");
        tick();
        idle(); set_rd(1, 1'b1, 5'd9);
        #1 chk("set_wins", 32'(rd_busy_o[1]), 32'h1);
        check_all("set_wins_all");
        idle();
        wb1_we_i = 1'b1; wb1_addr_i = 5'd9; wb1_data_i = 32'h9A;
        tick();

        // Randomized traffic on a narrow address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            rd_en_i    = NRD'($urandom_range(0, 3));
            set_rd(0, rd_en_i[0], AW'($urandom_range(0, 7)));
            set_rd(1, rd_en_i[1], AW'($urandom_range(0, 7)));
            wb0_we_i   = ($urandom_range(0, 2) == 0);
            wb0_addr_i = AW'($urandom_range(0, 7));
            wb0_data_i = $urandom;
            wb1_we_i   = ($urandom_range(0, 2) == 0);
            wb1_addr_i = AW'($urandom_range(0, 7));
            wb1_data_i = $urandom;
            iss_we_i   = ($urandom_range(0, 1) == 0);
            iss_addr_i = AW'($urandom_range(0, 7));
            #1 check_all("rnd");
            tick();
        end

        // Mid-cycle asynchronous reset, then first edge after release takes effect.
        idle();
        wb0_we_i = 1'b1; wb0_addr_i = 5'd10; wb0_data_i = 32'hA5A5A5A5;
        iss_we_i = 1'b1; iss_addr_i = 5'd11;
        wb1_we_i = 1'b1; wb1_addr_i = 5'd11; wb1_data_i = 32'h0;
        tick();
        idle(); set_rd(0, 1'b1, 5'd10); set_rd(1, 1'b1, 5'd11);
        #1 chk("pre_rst_x10", rd_data_o[31:0], 32'hA5A5A5A5);
        chk("pre_rst_x11_busy", 32'(rd_busy_o[1]), 32'h1);
        rest = 1'b0;
        model_clear();
        #1 check_all("async_rst");
        rest = 1'b1;
        #1 chk("async_x10", rd_data_o[31:0], 32'h0);
        chk("async_x11_busy", 32'(rd_busy_o[1]), 32'h0);
        check_all("async_after");
        idle();
        iss_we_i = 1'b1; iss_addr_i = 5'd12;
        wb0_we_i = 1'b1; wb0_addr_i = 5'd13; wb0_data_i = 32'h13131313;
        tick();
        idle(); set_rd(0, 1'b1, 5'd12); set_rd(1, 1'b1, 5'd13);
        #1 chk("first_edge_iss", 32'(rd_busy_o[0]), 32'h1);
        chk("first_edge_wr", rd_data_o[63:32], 32'h13131313);
        check_all("first_edge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
